fetch_unit: RTL and testbench

//  Producer side of the IF/ID interface: owns the PC, issues requests to instruction memory,
//  and presents instr_F / PC_F / PCP4_F / valid_F to the IF/ID pipeline register.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_branch_predecode.sv | 36 +++
 rtl/fetch_unit.sv | 168 ++++++++++++++++
 tb/tb_fetch_unit.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
    localparam logic [6:0]  OPC_JAL    = 7'b1101111;
    localparam logic [6:0]  OPC_BRANCH = 7'b1100011;

endpackage

// File: rtl/fetch_branch_predecode.sv
// Static backward-taken / forward-not-taken predecode of a fetched instruction.
// Only built when BTFN_PREDICT_EN is defined; returns {taken, next_pc}.
`ifdef BTFN_PREDICT_EN
module branch_predecode
    import fetch_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_pc,
    input  logic [31:0]      i_instr,
    output logic [WIDTH:0]   o_pred
);

    logic [WIDTH-1:0] w_imm_j;
    logic [WIDTH-1:0] w_imm_b;
    logic             w_is_jal;
    logic             w_is_bwd;

    // Extract J/B immediates and pick the predicted next fetch address.
    always_comb begin
        w_imm_j  = {{(WIDTH-20){i_instr[31]}}, i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
        w_imm_b  = {{(WIDTH-12){i_instr[31]}}, i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
        w_is_jal = (i_instr[6:0] == OPC_JAL);
        // Sign bit of the B immediate is instr[31]: set means a backward branch.
        w_is_bwd = (i_instr[6:0] == OPC_BRANCH) && i_instr[31];
        if (w_is_jal) begin
            o_pred = {1'b1, i_pc + w_imm_j};
        end else if (w_is_bwd) begin
            o_pred = {1'b1, i_pc + w_imm_b};
        end else begin
            o_pred = {1'b0, i_pc + WIDTH'(4)};
        end
    end

endmodule
`endif

// File: rtl/fetch_unit.sv
// Instruction fetch unit: owns the PC, issues one outstanding request at a time to
// instruction memory and presents the fetched instruction to the IF/ID register.
// Handshake: a request is held (imem_req/imem_addr stable) until imem_gnt is seen
// high on a rising edge; exactly one imem_rvalid follows each grant, at any later cycle.
// Optional static prediction is enabled with the BTFN_PREDICT_EN macro.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_F,
    input  logic             redirect_E,
    input  logic [WIDTH-1:0] PCTarget_E,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_gnt,
    input  logic             imem_rvalid,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic [WIDTH-1:0] instr_F,
    output logic [WIDTH-1:0] PC_F,
    output logic [WIDTH-1:0] PCP4_F,
    output logic             valid_F,
`ifdef BTFN_PREDICT_EN
    output logic             pred_taken_F,
`endif
    output fetch_state_t     o_dbg_state
);

    fetch_state_t     r_state;
    fetch_state_t     w_state_nxt;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] w_pc_nxt;
    logic             r_kill;
    logic             w_kill_nxt;
    logic             w_accept;
    logic [WIDTH-1:0] w_target;
    logic [WIDTH-1:0] w_pc_plus4;
    logic [WIDTH-1:0] w_next_pc;
    logic [WIDTH-1:0] r_instr;
    logic [WIDTH-1:0] r_pc_f;
    logic [WIDTH-1:0] r_pcp4_f;
    logic             r_valid;

    // Redirect targets are word aligned: the two low bits are dropped.
    assign w_target   = PCTarget_E & ~WIDTH'(3);
    assign w_pc_plus4 = r_pc + WIDTH'(4);
    assign imem_addr  = r_pc;

`ifdef BTFN_PREDICT_EN
    logic [WIDTH:0] w_pred;
    logic           r_pred;

    branch_predecode #(.WIDTH(WIDTH)) u_predecode (
        .i_pc    (r_pc),
        .i_instr (imem_rdata[31:0]),
        .o_pred  (w_pred)
    );
    assign w_next_pc    = w_pred[WIDTH-1:0];
    assign pred_taken_F = r_pred;
`else
    assign w_next_pc = w_pc_plus4;
`endif

    // Next-state, PC and kill-flag logic; redirect outranks stall and responses.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_kill_nxt  = r_kill;
        w_accept    = 1'b0;
        imem_req    = 1'b0;
        case (r_state)
            IDLE: begin
                w_state_nxt = REQ;
                if (redirect_E) w_pc_nxt = w_target;
            end
            REQ: begin
                imem_req = 1'b1;
                if (redirect_E) begin
                    w_pc_nxt = w_target;
                    // Granted in the same cycle: the address already left, so kill its reply.
                    if (imem_gnt) begin
                        w_kill_nxt  = 1'b1;
                        w_state_nxt = WAIT;
                    end
                end else if (imem_gnt) begin
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (redirect_E) begin
                    w_pc_nxt = w_target;
                    if (imem_rvalid) begin
                        w_kill_nxt  = 1'b0;
                        w_state_nxt = REQ;
                    end else begin
                        w_kill_nxt  = 1'b1;
                    end
                end else if (imem_rvalid) begin
                    if (r_kill) begin
                        w_kill_nxt  = 1'b0;
                        w_state_nxt = REQ;
                    end else begin
                        w_accept    = 1'b1;
                        w_pc_nxt    = w_next_pc;
                        w_state_nxt = stall_F ? HOLD : REQ;
                    end
                end
            end
            HOLD: begin
                if (redirect_E) begin
                    w_pc_nxt    = w_target;
                    w_state_nxt = REQ;
                end else if (!stall_F) begin
                    w_state_nxt = REQ;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM state, PC and kill flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_pc    <= RESET_PC;
            r_kill  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_kill  <= w_kill_nxt;
        end
    end

    // IF/ID-facing outputs: load on accepted data, hold under stall, bubble otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid  <= 1'b0;
            r_instr  <= WIDTH'(NOP_INSTR);
            r_pc_f   <= '0;
            r_pcp4_f <= '0;
`ifdef BTFN_PREDICT_EN
            r_pred   <= 1'b0;
`endif
        end else if (redirect_E) begin
            r_valid  <= 1'b0;
        end else if (w_accept) begin
            r_valid  <= 1'b1;
            r_instr  <= imem_rdata;
            r_pc_f   <= r_pc;
            r_pcp4_f <= w_pc_plus4;
`ifdef BTFN_PREDICT_EN
            r_pred   <= w_pred[WIDTH];
`endif
        end else if (!stall_F) begin
            r_valid  <= 1'b0;
        end
    end

    assign instr_F     = r_instr;
    assign PC_F        = r_pc_f;
    assign PCP4_F      = r_pcp4_f;
    assign valid_F     = r_valid;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed stimulus with a memory model, an expected-address
// queue checked on each grant and an expected-output queue checked on each new valid_F.
`timescale 1ns/1ps
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int W = 32;
`ifdef BTFN_PREDICT_EN
    localparam bit BTFN = 1'b1;
`else
    localparam bit BTFN = 1'b0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         stall_F = 1'b0;
    logic         redirect_E = 1'b0;
    logic [W-1:0] PCTarget_E = '0;
    logic         imem_req;
    logic [W-1:0] imem_addr;
    logic         imem_gnt = 1'b0;
    logic         imem_rvalid = 1'b0;
    logic [W-1:0] imem_rdata = '0;
    logic [W-1:0] instr_F;
    logic [W-1:0] PC_F;
    logic [W-1:0] PCP4_F;
    logic         valid_F;
    fetch_state_t dbg_state;
`ifdef BTFN_PREDICT_EN
    logic         pred_taken_F;
`endif

    always #5 clk = ~clk;

    fetch_unit #(.WIDTH(W), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .stall_F(stall_F), .redirect_E(redirect_E),
        .PCTarget_E(PCTarget_E), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_F(instr_F), .PC_F(PC_F), .PCP4_F(PCP4_F), .valid_F(valid_F),
`ifdef BTFN_PREDICT_EN
        .pred_taken_F(pred_taken_F),
`endif
        .o_dbg_state(dbg_state)
    );

    // ---------------- shared bench state ----------------
    int           checks = 0;
    int           errors = 0;
    int           wait_timeouts = 0;
    logic [W-1:0] exp_q[$];       // expected PC_F of each delivered instruction
    logic [W-1:0] exp_pred_q[$];  // expected pred_taken_F alongside exp_q
    logic [W-1:0] exp_addr_q[$];  // expected imem_addr of each granted request
    logic         in_reset = 1'b1;
    logic         expect_no_req = 1'b0;
    logic         mem_off = 1'b0;
    logic         done = 1'b0;
    int           gnt_delay = 0;
    int           rv_delay = 1;

    // Memory contents: a few hand-encoded control-flow instructions, ADDI-style filler elsewhere.
    function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
        case (a)
            32'h0000_0100: mem_word = 32'hFE00_0CE3;  // beq x0,x0,-8
            32'h0000_0140: mem_word = 32'h0000_0863;  // beq x0,x0,+16
            32'h0000_0040: mem_word = 32'h0200_006F;  // jal x0,+0x20
            default:       mem_word = {a[24:0], 7'b0010011};
        endcase
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_out(input logic [W-1:0] pc, input logic pred);
        exp_q.push_back(pc);
        exp_pred_q.push_back(W'(pred));
    endtask

    task automatic wait_for(input fetch_state_t st, input logic [W-1:0] a, input int budget);
        int n;
        n = 0;
        while (!(dbg_state == st && imem_addr == a) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) wait_timeouts++;
    endtask

    task automatic redirect_to(input logic [W-1:0] t);
        redirect_E = 1'b1;
        PCTarget_E = t;
        tick();
        redirect_E = 1'b0;
    endtask

    // ---------------- memory model + monitor / scoreboard ----------------
    logic         pend = 1'b0;
    int           rcnt = 0;
    int           req_age = 0;
    logic [W-1:0] paddr = '0;
    logic         prev_req = 1'b0, prev_gnt = 1'b0, prev_redirect = 1'b0;
    logic         prev_valid = 1'b0, prev_stall = 1'b0;
    logic [W-1:0] prev_addr = '0, prev_pc_f = '0, prev_instr = '0;
    logic [W-1:0] e_pc, e_pred;
    int           cycle = 0;

    always @(negedge clk) begin
        cycle++;
        imem_rvalid = 1'b0;
        imem_gnt    = 1'b0;
        if (rst) begin
            pend    = 1'b0;
            req_age = 0;
        end else begin
            if (pend) begin
                rcnt--;
                if (rcnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = mem_word(paddr);
                    pend        = 1'b0;
                end
            end
            if (expect_no_req) chk("no_req_in_stall", W'(imem_req), '0);
            if (imem_req) begin
                chk("one_outstanding", W'(pend), '0);
                if (prev_req && !prev_gnt && !prev_redirect)
                    chk("addr_stable_until_gnt", imem_addr, prev_addr);
                if (!mem_off && req_age >= gnt_delay) begin
                    imem_gnt = 1'b1;
                    paddr    = imem_addr;
                    pend     = 1'b1;
                    rcnt     = rv_delay;
                    req_age  = 0;
                    if (exp_addr_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_grant: got addr %h expected none", imem_addr);
                    end else begin
                        chk("grant_addr", imem_addr, exp_addr_q.pop_front());
                    end
                end else begin
                    req_age++;
                end
            end else begin
                req_age = 0;
            end
        end

        if (in_reset) begin
            chk("reset_valid_F", W'(valid_F), '0);
            chk("reset_instr_F", instr_F, NOP_INSTR);
            chk("reset_PC_F", PC_F, '0);
            chk("reset_imem_req", W'(imem_req), '0);
        end else if (prev_valid && prev_stall && !prev_redirect) begin
            chk("stall_hold_valid", W'(valid_F), W'(1'b1));
            chk("stall_hold_PC_F", PC_F, prev_pc_f);
            chk("stall_hold_instr_F", instr_F, prev_instr);
        end else if (valid_F) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got PC_F %h expected none", PC_F);
            end else begin
                e_pc   = exp_q.pop_front();
                e_pred = exp_pred_q.pop_front();
                chk("out_PC_F", PC_F, e_pc);
                chk("out_PCP4_F", PCP4_F, e_pc + 32'd4);
                chk("out_instr_F", instr_F, mem_word(e_pc));
`ifdef BTFN_PREDICT_EN
                chk("out_pred_taken_F", W'(pred_taken_F), e_pred);
`endif
            end
        end

        prev_req      = imem_req;
        prev_gnt      = imem_gnt;
        prev_addr     = imem_addr;
        prev_redirect = redirect_E;
        prev_valid    = valid_F;
        prev_stall    = stall_F;
        prev_pc_f     = PC_F;
        prev_instr    = instr_F;

        if (done || cycle > 5000) begin
            if (!done) begin
                errors++;
                $display("FAIL global_timeout: got cycle %0d expected below 5000", cycle);
            end
            chk("wait_timeouts", W'(wait_timeouts), '0);
            chk("outputs_all_seen", W'(exp_q.size()), '0);
            chk("grants_all_seen", W'(exp_addr_q.size()), '0);
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    // ---------------- directed stimulus ----------------
    logic [W-1:0] nb, nj;

    initial begin
        nb = BTFN ? 32'h0000_00F8 : 32'h0000_0104;
        nj = BTFN ? 32'h0000_0060 : 32'h0000_0044;

        // Reset sequence, fast memory: fetches 0x0, 0x4, 0x8 in order.
        for (int a = 0; a <= 16; a += 4) exp_addr_q.push_back(W'(a));
        push_out(32'h0, 1'b0);
        push_out(32'h4, 1'b0);
        push_out(32'h8, 1'b0);
        push_out(32'hC, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        in_reset = 1'b0;

        // Stall while 0x8 is delivered: outputs frozen, no new request, then 0xC.
        wait_for(WAIT, 32'h8, 50);
        stall_F = 1'b1;
        expect_no_req = 1'b1;
        repeat (4) tick();
        stall_F = 1'b0;
        expect_no_req = 1'b0;

        // Redirect while waiting for the 0x10 reply; low target bits must be ignored.
        rv_delay = 3;
        wait_for(WAIT, 32'h10, 50);
        redirect_to(32'h0000_0203);

        // Slow memory: grant after 3 cycles, reply 2 cycles later.
        gnt_delay = 3;
        rv_delay = 2;
        exp_addr_q.push_back(32'h200); push_out(32'h200, 1'b0);
        exp_addr_q.push_back(32'h204); push_out(32'h204, 1'b0);
        exp_addr_q.push_back(32'h208); push_out(32'h208, 1'b0);
        exp_addr_q.push_back(32'h20C);
        wait_for(WAIT, 32'h208, 100);
        gnt_delay = 0;
        rv_delay = 1;

        // Redirect + stall together, coinciding with the 0x20C reply: reply dropped.
        wait_for(WAIT, 32'h20C, 50);
        stall_F = 1'b1;
        redirect_to(32'h300);
        stall_F = 1'b0;
        exp_addr_q.push_back(32'h300); push_out(32'h300, 1'b0);
        exp_addr_q.push_back(32'h400); push_out(32'h400, 1'b0);
        exp_addr_q.push_back(32'h404);
        // Stall into HOLD on 0x300, then redirect while held.
        wait_for(WAIT, 32'h300, 50);
        stall_F = 1'b1;
        tick();
        redirect_to(32'h400);
        stall_F = 1'b0;

        // Redirect in REQ with same-cycle grant: 0x404 reply killed.
        wait_for(REQ, 32'h404, 50);
        exp_addr_q.push_back(32'h100); push_out(32'h100, BTFN);
        exp_addr_q.push_back(nb);      push_out(nb, 1'b0);
        exp_addr_q.push_back(nb + 32'h4);
        redirect_to(32'h100);

        // Backward BEQ at 0x100, then forward BEQ at 0x140.
        wait_for(REQ, nb + 32'h4, 50);
        exp_addr_q.push_back(32'h140); push_out(32'h140, 1'b0);
        exp_addr_q.push_back(32'h144); push_out(32'h144, 1'b0);
        exp_addr_q.push_back(32'h148);
        redirect_to(32'h140);

        // JAL +0x20 at 0x40.
        wait_for(REQ, 32'h148, 50);
        exp_addr_q.push_back(32'h40); push_out(32'h40, BTFN);
        exp_addr_q.push_back(nj);     push_out(nj, 1'b0);
        exp_addr_q.push_back(nj + 32'h4);
        redirect_to(32'h40);

        // PC wrap: 0xFFFF_FFFC has PCP4_F of 0, next fetch at 0x0.
        wait_for(REQ, nj + 32'h4, 50);
        exp_addr_q.push_back(32'hFFFF_FFFC); push_out(32'hFFFF_FFFC, 1'b0);
        exp_addr_q.push_back(32'h0);         push_out(32'h0, 1'b0);
        exp_addr_q.push_back(32'h4);         push_out(32'h4, 1'b0);
        redirect_to(32'hFFFF_FFFC);

        // Stop granting once the 0x4 reply is pending, let it drain, then report.
        wait_for(WAIT, 32'h4, 50);
        mem_off = 1'b1;
        repeat (6) tick();
        done = 1'b1;
    end

endmodule
